// File: rtl/bomberman_pkg.sv
// Shared map/tile types and address helper for the bomberman map RAM agents.
package bomberman_pkg;

  // Tile state codes stored in the map RAM
  typedef enum logic [1:0] {
    NO_BLK          = 2'd0,
    PERM_BLK        = 2'd1,
    DESTROYABLE_BLK = 2'd2,
    BOMB            = 2'd3
  } map_state_t;

  // Blast scan directions, in scan order
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Map update controller states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CHECK      = 3'd1,
    ST_EVAL       = 3'd2,
    ST_FUSE       = 3'd3,
    ST_CLR_CENTER = 3'd4,
    ST_SCAN_RD    = 3'd5,
    ST_SCAN_EVAL  = 3'd6,
    ST_DONE       = 3'd7
  } ctrl_state_t;

  localparam int unsigned TILE_ADDR_W = 16;

  // Linear tile address: row*num_col + col (caller narrows to its RAM width)
  function automatic logic [TILE_ADDR_W-1:0] tile_addr(input logic [4:0]  row,
                                                       input logic [4:0]  col,
                                                       input int unsigned num_col);
    return TILE_ADDR_W'(32'(row) * num_col + 32'(col));
  endfunction

endpackage

// File: rtl/bomb_fuse_timer.sv
// Bomb fuse countdown: one-cycle expired pulse timed so the owning FSM
// leaves its wait state FUSE_CYCLES+1 cycles after the start cycle.
module bomb_fuse_timer #(
  parameter int unsigned FUSE_CYCLES = 200_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic expired
);

  localparam int unsigned CNT_W = (FUSE_CYCLES > 2) ? $clog2(FUSE_CYCLES) : 1;
  // Registered pulse plus one FSM transition cycle absorb two counts
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(FUSE_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             expired_q;

  // Countdown and expiry pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      run_q     <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (start) begin
        cnt_q <= LOAD_VAL;
        run_q <= 1'b1;
      end else if (run_q) begin
        if (cnt_q == '0) begin
          run_q     <= 1'b0;
          expired_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/map_update_ctrl.sv
// Write-side map RAM controller: validates and places one bomb, runs its
// fuse, then clears the center and blasts destroyable blocks in a cross.
module map_update_ctrl
  import bomberman_pkg::*;
#(
  parameter int unsigned MAP_MEM_WIDTH = 2,
  parameter int unsigned NUM_ROW       = 11,
  parameter int unsigned NUM_COL       = 19,
  parameter int unsigned FUSE_CYCLES   = 200_000_000,
  parameter int unsigned BLAST_RADIUS  = 2,
  localparam int unsigned ADDR_WIDTH   = $clog2(NUM_ROW * NUM_COL)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     place_req,
  input  logic [4:0]               place_row,
  input  logic [4:0]               place_col,
  output logic                     place_ack,
  output logic                     place_nack,
  output logic                     busy,
  output logic                     explode,
  output logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic [MAP_MEM_WIDTH-1:0] rd_data,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [MAP_MEM_WIDTH-1:0] wr_data
);

  localparam int unsigned      K_W       = $clog2(BLAST_RADIUS + 1);
  localparam logic signed [5:0] NUM_ROW_S = 6'(NUM_ROW);
  localparam logic signed [5:0] NUM_COL_S = 6'(NUM_COL);

  ctrl_state_t     state_q, state_d;
  logic [4:0]      row_q, row_d;
  logic [4:0]      col_q, col_d;
  dir_t            dir_q, dir_d;
  logic [K_W-1:0]  k_q, k_d;
  logic            nack_q, nack_d;

  logic            fuse_start_c;
  logic            fuse_expired_c;
  map_state_t      rd_tile_c;
  logic            req_in_range_c;
  logic [ADDR_WIDTH-1:0] center_addr_c;
  logic [ADDR_WIDTH-1:0] scan_addr_c;
  logic            scan_inb_c;
  logic signed [5:0] row_s_c, col_s_c, k_s_c, scan_row_c, scan_col_c;
  ctrl_state_t     adv_state_c;
  dir_t            adv_dir_c;

  bomb_fuse_timer #(
    .FUSE_CYCLES (FUSE_CYCLES)
  ) u_fuse (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (fuse_start_c),
    .expired (fuse_expired_c)
  );

  assign rd_tile_c      = map_state_t'(2'(rd_data));
  assign req_in_range_c = (32'(place_row) < NUM_ROW) && (32'(place_col) < NUM_COL);
  assign center_addr_c  = ADDR_WIDTH'(tile_addr(row_q, col_q, NUM_COL));

  // Blast target at distance k in the current direction, signed bounds check
  always_comb begin
    row_s_c    = $signed({1'b0, row_q});
    col_s_c    = $signed({1'b0, col_q});
    k_s_c      = $signed(6'(k_q));
    scan_row_c = row_s_c;
    scan_col_c = col_s_c;
    unique case (dir_q)
      DIR_UP:    scan_row_c = row_s_c - k_s_c;
      DIR_DOWN:  scan_row_c = row_s_c + k_s_c;
      DIR_LEFT:  scan_col_c = col_s_c - k_s_c;
      DIR_RIGHT: scan_col_c = col_s_c + k_s_c;
      default:   scan_row_c = row_s_c;
    endcase
    scan_inb_c  = (scan_row_c >= 6'sd0) && (scan_row_c < NUM_ROW_S) &&
                  (scan_col_c >= 6'sd0) && (scan_col_c < NUM_COL_S);
    scan_addr_c = ADDR_WIDTH'(tile_addr(5'(scan_row_c), 5'(scan_col_c), NUM_COL));
  end

  // Where to go once the current direction is finished
  always_comb begin
    adv_state_c = ST_SCAN_RD;
    adv_dir_c   = dir_t'(dir_q + 2'd1);
    if (dir_q == DIR_RIGHT) begin
      adv_state_c = ST_DONE;
      adv_dir_c   = DIR_UP;
    end
  end

  // State and latched-context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      dir_q   <= DIR_UP;
      k_q     <= '0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      k_q     <= k_d;
      nack_q  <= nack_d;
    end
  end

  // Next-state and RAM/handshake outputs
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    dir_d        = dir_q;
    k_d          = k_q;
    nack_d       = 1'b0;
    fuse_start_c = 1'b0;
    place_ack    = 1'b0;
    place_nack   = nack_q;
    busy         = 1'b0;
    explode      = 1'b0;
    rd_addr      = '0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (place_req) begin
          if (req_in_range_c) begin
            row_d   = place_row;
            col_d   = place_col;
            state_d = ST_CHECK;
          end else begin
            nack_d = 1'b1;
          end
        end
      end

      ST_CHECK: begin
        busy    = 1'b1;
        rd_addr = center_addr_c;
        state_d = ST_EVAL;
      end

      ST_EVAL: begin
        if (rd_tile_c == NO_BLK) begin
          busy         = 1'b1;
          wr_en        = 1'b1;
          wr_addr      = center_addr_c;
          wr_data      = MAP_MEM_WIDTH'(BOMB);
          place_ack    = 1'b1;
          fuse_start_c = 1'b1;
          state_d      = ST_FUSE;
        end else begin
          place_nack = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_FUSE: begin
        busy = 1'b1;
        if (fuse_expired_c) begin
          state_d = ST_CLR_CENTER;
        end
      end

      ST_CLR_CENTER: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = center_addr_c;
        wr_data = MAP_MEM_WIDTH'(NO_BLK);
        explode = 1'b1;
        dir_d   = DIR_UP;
        k_d     = K_W'(1);
        state_d = ST_SCAN_RD;
      end

      ST_SCAN_RD: begin
        busy = 1'b1;
        if (scan_inb_c) begin
          rd_addr = scan_addr_c;
          state_d = ST_SCAN_EVAL;
        end else begin
          // Off the map: drop the rest of this arm without a read
          state_d = adv_state_c;
          dir_d   = adv_dir_c;
          k_d     = K_W'(1);
        end
      end

      ST_SCAN_EVAL: begin
        busy = 1'b1;
        unique case (rd_tile_c)
          PERM_BLK: begin
            state_d = adv_state_c;
            dir_d   = adv_dir_c;
            k_d     = K_W'(1);
          end
          DESTROYABLE_BLK: begin
            wr_en   = 1'b1;
            wr_addr = scan_addr_c;
            wr_data = MAP_MEM_WIDTH'(NO_BLK);
            state_d = adv_state_c;
            dir_d   = adv_dir_c;
            k_d     = K_W'(1);
          end
          default: begin
            // Empty tile or another bomb: the blast passes through
            if (32'(k_q) < BLAST_RADIUS) begin
              k_d     = k_q + K_W'(1);
              state_d = ST_SCAN_RD;
            end else begin
              state_d = adv_state_c;
              dir_d   = adv_dir_c;
              k_d     = K_W'(1);
            end
          end
        endcase
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
